muldiv_unit: RTL and testbench

Multi-cycle multiply/divide unit in the EX stage of the P7 pipeline. It executes the operations issued by the ID-stage decode: mult, multu, div, divu and madd, plus mthi/mtlo writes and mfhi/mflo reads. It owns the HI/LO registers and reports `busy` so the hazard logic can stall later muldiv instructions. The pipeline can suppress any issue when an exception or interrupt is taken.

---
 rtl/mdu_pkg.sv | 32 +++
 rtl/muldiv_unit.sv | 219 +++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Shared definitions for the EX-stage multiply/divide unit:
//               operation codes driven on MDCCtrl, HI/LO move encodings on
//               MDM_WE / MDM_RE, and the control state enumeration.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    // Operation codes carried on MDCCtrl; any other value is a no-op.
    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MADD  = 3'd4;

    // mthi / mtlo write selects on MDM_WE.
    localparam logic [1:0] MDM_WE_HI = 2'b01;
    localparam logic [1:0] MDM_WE_LO = 2'b10;

    // mfhi / mflo read selects on MDM_RE.
    localparam logic [1:0] MDM_RE_HI = 2'b01;
    localparam logic [1:0] MDM_RE_LO = 2'b10;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_t;

endpackage : mdu_pkg
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Multi-cycle multiply/divide unit owning the HI/LO registers.
//               The result is computed when the operation is accepted, held
//               in hi_tmp/lo_tmp, and committed to HI/LO after the modelled
//               latency so the pipeline sees realistic busy timing.
// Revision    : 1.0 - initial release
//
// Configuration macro:
//   MDU_MADD_EN - when defined, op MDU_MADD accumulates the signed product
//                 into {HI,LO}; when undefined, op 4 is a no-op and the
//                 64-bit accumulate adder is not built.
//
// Ports:
//   clk      in  1   clock
//   reset    in  1   asynchronous reset, active low
//   start    in  1   issue pulse for the op on MDCCtrl
//   MDCCtrl  in  3   operation code (mdu_pkg MDU_*)
//   MDM_WE   in  2   01 = mthi, 10 = mtlo
//   MDM_RE   in  2   01 = read HI, 10 = read LO, else 0
//   A, B     in  32  rs / rt operands
//   req      in  1   exception/interrupt taken: blocks start and MDM_WE
//   busy     out 1   operation in flight (registered)
//   HI, LO   out 32  architectural register values
//   RD       out 32  read data selected by MDM_RE
// ============================================================================
module muldiv_unit
    import mdu_pkg::*;
#(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  MDCCtrl,
    input  logic [1:0]  MDM_WE,
    input  logic [1:0]  MDM_RE,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        req,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] RD
);

    localparam int c_CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    mdu_state_t           r_state;
    mdu_state_t           w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [31:0]          r_hi;
    logic [31:0]          r_lo;
    logic [31:0]          r_hi_tmp;
    logic [31:0]          r_lo_tmp;
    logic                 r_div0;

    // ------------------------------------------------------------------
    // Operation decode
    // ------------------------------------------------------------------
    logic w_op_valid;
    logic w_op_is_div;
    logic w_issue;
    logic w_last;

    always_comb begin
        w_op_valid  = 1'b0;
        w_op_is_div = 1'b0;
        case (MDCCtrl)
            MDU_MULT, MDU_MULTU: w_op_valid = 1'b1;
            MDU_DIV, MDU_DIVU: begin
                w_op_valid  = 1'b1;
                w_op_is_div = 1'b1;
            end
`ifdef MDU_MADD_EN
            MDU_MADD: w_op_valid = 1'b1;
`endif
            default: w_op_valid = 1'b0;
        endcase
    end

    assign w_issue = (r_state == ST_IDLE) && start && !req && w_op_valid;
    assign w_last  = (r_state == ST_RUN) && (r_cnt == c_CNT_W'(1));

    // ------------------------------------------------------------------
    // Arithmetic
    // ------------------------------------------------------------------
    logic [63:0]        w_a_sx;
    logic [63:0]        w_b_sx;
    logic [63:0]        w_prod_s;
    logic [63:0]        w_prod_u;
    logic               w_b_zero;
    logic [31:0]        w_b_safe;
    logic signed [31:0] w_quot_s;
    logic signed [31:0] w_rem_s;
    logic [31:0]        w_quot_u;
    logic [31:0]        w_rem_u;
    logic [31:0]        w_res_hi;
    logic [31:0]        w_res_lo;

    // Sign-extending to 64 bits keeps the low 64 product bits correct for
    // signed operands without relying on expression-context sign rules.
    assign w_a_sx   = {{32{A[31]}}, A};
    assign w_b_sx   = {{32{B[31]}}, B};
    assign w_prod_s = w_a_sx * w_b_sx;
    assign w_prod_u = {32'd0, A} * {32'd0, B};

    // Divide by zero never commits; substituting 1 keeps the divider
    // free of X so hi_tmp/lo_tmp stay clean.
    assign w_b_zero = (B == 32'd0);
    assign w_b_safe = w_b_zero ? 32'd1 : B;
    assign w_quot_s = $signed(A) / $signed(w_b_safe);
    assign w_rem_s  = $signed(A) % $signed(w_b_safe);
    assign w_quot_u = A / w_b_safe;
    assign w_rem_u  = A % w_b_safe;

`ifdef MDU_MADD_EN
    logic [63:0] w_acc;
    // {HI,LO} is sampled at issue; the carry out of bit 63 is dropped.
    assign w_acc = {r_hi, r_lo} + w_prod_s;
`endif

    always_comb begin
        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
        case (MDCCtrl)
            MDU_MULT:  {w_res_hi, w_res_lo} = w_prod_s;
            MDU_MULTU: {w_res_hi, w_res_lo} = w_prod_u;
            MDU_DIV: begin
                w_res_hi = w_rem_s;
                w_res_lo = w_quot_s;
            end
            MDU_DIVU: begin
                w_res_hi = w_rem_u;
                w_res_lo = w_quot_u;
            end
`ifdef MDU_MADD_EN
            MDU_MADD:  {w_res_hi, w_res_lo} = w_acc;
`endif
            default: begin
                w_res_hi = 32'd0;
                w_res_lo = 32'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_issue) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last)  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_hi_tmp <= 32'd0;
            r_lo_tmp <= 32'd0;
            r_div0   <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            if (w_issue) begin
                r_hi_tmp <= w_res_hi;
                r_lo_tmp <= w_res_lo;
                r_div0   <= w_op_is_div && w_b_zero;
                r_cnt    <= w_op_is_div ? c_CNT_W'(DIV_CYCLES) : c_CNT_W'(MUL_CYCLES);
            end
            // Moves only land while idle; during RUN they are ignored.
            if (!req) begin
                if (MDM_WE == MDM_WE_HI) r_hi <= A;
                if (MDM_WE == MDM_WE_LO) r_lo <= A;
            end
        end else begin
            r_cnt <= r_cnt - c_CNT_W'(1);
            if (w_last && !r_div0) begin
                r_hi <= r_hi_tmp;
                r_lo <= r_lo_tmp;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy = (r_state == ST_RUN);
    assign HI   = r_hi;
    assign LO   = r_lo;

    always_comb begin
        RD = 32'd0;
        case (MDM_RE)
            MDM_RE_HI: RD = r_hi;
            MDM_RE_LO: RD = r_lo;
            default:   RD = 32'd0;
        endcase
    end

endmodule : muldiv_unit
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Directed self-checking bench for muldiv_unit. Inputs change
//               on the falling edge; outputs are sampled on the falling edge
//               before any input change. Expected values are hand-computed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  MDCCtrl;
    logic [1:0]  MDM_WE;
    logic [1:0]  MDM_RE;
    logic [31:0] A;
    logic [31:0] B;
    logic        req;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] RD;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(
        .MUL_CYCLES (5),
        .DIV_CYCLES (10)
    ) u_dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .MDCCtrl (MDCCtrl),
        .MDM_WE  (MDM_WE),
        .MDM_RE  (MDM_RE),
        .A       (A),
        .B       (B),
        .req     (req),
        .busy    (busy),
        .HI      (HI),
        .LO      (LO),
        .RD      (RD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op, then count busy cycles (bounded) until it drops.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int exp_cycles);
        int n;
        @(negedge clk);
        start   = 1'b1;
        MDCCtrl = op;
        A       = a;
        B       = b;
        #1;
        check({tag, "_busy_comb"}, {31'd0, busy}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        A     = 32'd0;
        B     = 32'd0;
        n     = 0;
        while (busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, n, exp_cycles);
    endtask

    task automatic move(input logic [1:0] we, input logic [31:0] a);
        @(negedge clk);
        MDM_WE = we;
        A      = a;
        @(negedge clk);
        MDM_WE = 2'b00;
        A      = 32'd0;
    endtask

    initial begin
        reset   = 1'b0;
        start   = 1'b0;
        MDCCtrl = 3'd0;
        MDM_WE  = 2'b00;
        MDM_RE  = 2'b01;
        A       = 32'd0;
        B       = 32'd0;
        req     = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        check("rst_rd", RD, 32'd0);
        reset = 1'b1;

        // mult -1 * 2
        run_op("mult", 3'd0, 32'hFFFF_FFFF, 32'd2, 5);
        check("mult_hi", HI, 32'hFFFF_FFFF);
        check("mult_lo", LO, 32'hFFFF_FFFE);
        MDM_RE = 2'b01; #1;
        check("mult_rd_hi", RD, 32'hFFFF_FFFF);
        MDM_RE = 2'b10; #1;
        check("mult_rd_lo", RD, 32'hFFFF_FFFE);
        MDM_RE = 2'b11; #1;
        check("rd_none", RD, 32'd0);

        // multu 0xFFFFFFFF * 2
        run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, 5);
        check("multu_hi", HI, 32'h0000_0001);
        check("multu_lo", LO, 32'hFFFF_FFFE);

        // div -7 / 2
        run_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2, 10);
        check("div_lo", LO, 32'hFFFF_FFFD);
        check("div_hi", HI, 32'hFFFF_FFFF);

        // div 7 / -2 : quotient -3, remainder +1
        run_op("div2", 3'd2, 32'd7, 32'hFFFF_FFFE, 10);
        check("div2_lo", LO, 32'hFFFF_FFFD);
        check("div2_hi", HI, 32'h0000_0001);

        // divu 100 / 7
        run_op("divu", 3'd3, 32'd100, 32'd7, 10);
        check("divu_lo", LO, 32'd14);
        check("divu_hi", HI, 32'd2);

        // mthi then divide by zero leaves HI/LO alone
        move(2'b01, 32'h0000_1234);
        MDM_RE = 2'b01; #1;
        check("mthi_rd", RD, 32'h0000_1234);
        run_op("divz", 3'd3, 32'd5, 32'd0, 10);
        check("divz_hi", HI, 32'h0000_1234);
        check("divz_lo", LO, 32'd14);

        // mtlo visible next cycle
        move(2'b10, 32'hCAFE_0001);
        MDM_RE = 2'b10; #1;
        check("mtlo_rd", RD, 32'hCAFE_0001);

        // start + mtlo blocked by req
        @(negedge clk);
        req     = 1'b1;
        start   = 1'b1;
        MDCCtrl = 3'd0;
        MDM_WE  = 2'b10;
        A       = 32'd3;
        B       = 32'd3;
        @(negedge clk);
        req    = 1'b0;
        start  = 1'b0;
        MDM_WE = 2'b00;
        check("req_busy", {31'd0, busy}, 32'd0);
        check("req_lo", LO, 32'hCAFE_0001);
        check("req_hi", HI, 32'h0000_1234);

        // Out-of-range op: no busy, no change
        @(negedge clk);
        start   = 1'b1;
        MDCCtrl = 3'd6;
        A       = 32'd9;
        B       = 32'd9;
        @(negedge clk);
        start = 1'b0;
        check("oor_busy", {31'd0, busy}, 32'd0);
        check("oor_lo", LO, 32'hCAFE_0001);

        // mthi while busy is ignored
        @(negedge clk);
        start   = 1'b1;
        MDCCtrl = 3'd0;
        A       = 32'd3;
        B       = 32'd4;
        @(negedge clk);
        start  = 1'b0;
        MDM_WE = 2'b01;
        A      = 32'h0000_DEAD;
        check("ign_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        MDM_WE = 2'b00;
        repeat (5) @(negedge clk);
        check("ign_done", {31'd0, busy}, 32'd0);
        check("ign_hi", HI, 32'd0);
        check("ign_lo", LO, 32'd12);

`ifdef MDU_MADD_EN
        move(2'b01, 32'd0);
        move(2'b10, 32'hFFFF_FFFF);
        run_op("madd", 3'd4, 32'd1, 32'd1, 5);
        check("madd_hi", HI, 32'h0000_0001);
        check("madd_lo", LO, 32'h0000_0000);
`else
        @(negedge clk);
        start   = 1'b1;
        MDCCtrl = 3'd4;
        A       = 32'd1;
        B       = 32'd1;
        @(negedge clk);
        start = 1'b0;
        check("madd_off_busy", {31'd0, busy}, 32'd0);
        check("madd_off_lo", LO, 32'd12);
`endif

        // Reset mid-operation aborts immediately
        @(negedge clk);
        start   = 1'b1;
        MDCCtrl = 3'd1;
        A       = 32'd5;
        B       = 32'd5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("mid_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_hi", HI, 32'd0);
        check("arst_lo", LO, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (7) @(negedge clk);
        check("arst_stay_busy", {31'd0, busy}, 32'd0);
        check("arst_stay_lo", LO, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_muldiv_unit
`default_nettype wire
